// File: rtl/conv_frame_sequencer.sv
// -----------------------------------------------------------------------------
// conv_frame_sequencer
//
// Sequences one image frame through an external 3x3 convolution filter.
// The sequencer loads the active kernel from a shadow coefficient bank,
// forwards source pixels to the filter, forwards filter results to the sink,
// counts beats in both directions and reports the end of the frame.
//
// Optional feature (compile-time macro CONV_SEQ_TIMEOUT_EN):
//   Adds a drain watchdog. If no output beat arrives for TIMEOUT_CYCLES
//   consecutive DRAIN cycles, the sticky timeout flag is raised and the frame
//   is closed. Without the macro there is no watchdog and timeout is tied 0.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   frame start pulse (honoured in IDLE only)
//   busy                    frame in progress (LOAD/STREAM/DRAIN/DONE)
//   frame_done              one-cycle end-of-frame pulse
//   timeout                 sticky drain watchdog flag
//   cfg_we/cfg_addr/cfg_data shadow coefficient write (index 0..8, row-major)
//   kernel                  active signed 3x3 kernel driven to the filter
//   src_*                   pixel source (valid/ready/data)
//   flt_x_*                 pixels towards the filter
//   flt_y_*                 results from the filter
//   dst_*                   result sink
//   in_count/out_count      accepted input / delivered output beats
// -----------------------------------------------------------------------------
module conv_frame_sequencer #(
    parameter int  IMG_WIDTH      = 640,
    parameter int  IMG_HEIGHT     = 480,
    parameter int  W              = 8,
    parameter int  TIMEOUT_CYCLES = 4096,
    localparam int N              = IMG_WIDTH * IMG_HEIGHT,
    localparam int CW             = $clog2(N + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                frame_done,
    output logic                timeout,
    input  logic                cfg_we,
    input  logic [3:0]          cfg_addr,
    input  logic signed [W-1:0] cfg_data,
    output logic signed [W-1:0] kernel [0:2][0:2],
    input  logic                src_valid,
    output logic                src_ready,
    input  logic [W-1:0]        src_data,
    output logic                flt_x_valid,
    input  logic                flt_x_ready,
    output logic [W-1:0]        flt_x_data,
    input  logic                flt_y_valid,
    output logic                flt_y_ready,
    input  logic [W-1:0]        flt_y_data,
    output logic                dst_valid,
    input  logic                dst_ready,
    output logic [W-1:0]        dst_data,
    output logic [CW-1:0]       in_count,
    output logic [CW-1:0]       out_count
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t               r_state;
    logic                 r_busy;
    logic                 r_frame_done;
    logic [CW-1:0]        r_in_count;
    logic [CW-1:0]        r_out_count;
    logic signed [W-1:0]  r_shadow [0:8];
    logic signed [W-1:0]  r_kernel [0:2][0:2];

    logic                 w_in_beat;
    logic                 w_out_beat;
    logic [CW-1:0]        w_in_next;
    logic [CW-1:0]        w_out_next;

`ifdef CONV_SEQ_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0]       r_wd;
    logic                 r_timeout;
    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign in_count   = r_in_count;
    assign out_count  = r_out_count;
    assign kernel     = r_kernel;

    // Handshake routing: input path open only in STREAM, output path in STREAM and DRAIN.
    always_comb begin
        src_ready   = 1'b0;
        flt_x_valid = 1'b0;
        flt_x_data  = src_data;
        flt_y_ready = 1'b0;
        dst_valid   = 1'b0;
        dst_data    = flt_y_data;
        case (r_state)
            ST_STREAM: begin
                src_ready   = flt_x_ready;
                flt_x_valid = src_valid;
                flt_y_ready = dst_ready;
                dst_valid   = flt_y_valid;
            end
            ST_DRAIN: begin
                flt_y_ready = dst_ready;
                dst_valid   = flt_y_valid;
            end
            default: begin
            end
        endcase
    end

    // Next counter values; the output counter saturates at one full frame.
    always_comb begin
        w_in_beat  = flt_x_valid && flt_x_ready;
        w_out_beat = dst_valid && dst_ready;
        if (w_in_beat) begin
            w_in_next = r_in_count + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            w_in_next = r_in_count;
        end
        if (w_out_beat && (r_out_count != CW'(N))) begin
            w_out_next = r_out_count + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            w_out_next = r_out_count;
        end
    end

    // Shadow coefficient bank, writable in every state; out-of-range indices are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (cfg_we && (cfg_addr <= 4'd8)) begin
            r_shadow[cfg_addr] <= cfg_data;
        end
    end

    // Frame FSM with registered status, counters and kernel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_in_count   <= '0;
            r_out_count  <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_kernel[r][c] <= '0;
                end
            end
`ifdef CONV_SEQ_TIMEOUT_EN
            r_wd         <= '0;
            r_timeout    <= 1'b0;
`endif
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_busy <= start;
                    if (start) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // Old shadow values are taken, so a write in this cycle waits for the next LOAD.
                    for (int r = 0; r < 3; r++) begin
                        for (int c = 0; c < 3; c++) begin
                            r_kernel[r][c] <= r_shadow[r*3 + c];
                        end
                    end
                    r_in_count  <= '0;
                    r_out_count <= '0;
`ifdef CONV_SEQ_TIMEOUT_EN
                    r_timeout   <= 1'b0;
`endif
                    r_state     <= ST_STREAM;
                end
                ST_STREAM: begin
                    r_in_count  <= w_in_next;
                    r_out_count <= w_out_next;
                    if (w_in_beat && (w_in_next == CW'(N))) begin
                        r_state <= ST_DRAIN;
`ifdef CONV_SEQ_TIMEOUT_EN
                        r_wd    <= '0;
`endif
                    end
                end
                ST_DRAIN: begin
                    r_out_count <= w_out_next;
                    if (w_out_next == CW'(N)) begin
                        r_state      <= ST_DONE;
                        r_frame_done <= 1'b1;
                    end
`ifdef CONV_SEQ_TIMEOUT_EN
                    else if (w_out_beat) begin
                        r_wd <= '0;
                    end else if (r_wd == WDW'(TIMEOUT_CYCLES - 1)) begin
                        // This cycle completes the TIMEOUT_CYCLES-th idle drain cycle.
                        r_timeout    <= 1'b1;
                        r_state      <= ST_DONE;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_wd <= r_wd + {{(WDW-1){1'b0}}, 1'b1};
                    end
`endif
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for conv_frame_sequencer (IMG 4x2, N=8, TIMEOUT_CYCLES=16).
// An echo filter model sits between flt_x and flt_y. Every pixel issued by the
// stimulus is pushed to a scoreboard queue; an independent monitor pops and
// compares on every dst beat and checks frame_done framing.
// -----------------------------------------------------------------------------
module tb_conv_frame_sequencer;

    localparam int IW = 4;
    localparam int IH = 2;
    localparam int W  = 8;
    localparam int TO = 16;
    localparam int CW = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic                busy;
    logic                frame_done;
    logic                timeout;
    logic                cfg_we;
    logic [3:0]          cfg_addr;
    logic signed [W-1:0] cfg_data;
    logic signed [W-1:0] kernel [0:2][0:2];
    logic                src_valid;
    logic                src_ready;
    logic [W-1:0]        src_data;
    logic                flt_x_valid;
    logic                flt_x_ready;
    logic [W-1:0]        flt_x_data;
    logic                flt_y_valid;
    logic                flt_y_ready;
    logic [W-1:0]        flt_y_data;
    logic                dst_valid;
    logic                dst_ready;
    logic [W-1:0]        dst_data;
    logic [CW-1:0]       in_count;
    logic [CW-1:0]       out_count;

    always #5 clk = ~clk;

    conv_frame_sequencer #(
        .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .W(W), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .frame_done(frame_done), .timeout(timeout),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .kernel(kernel),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .flt_x_valid(flt_x_valid), .flt_x_ready(flt_x_ready), .flt_x_data(flt_x_data),
        .flt_y_valid(flt_y_valid), .flt_y_ready(flt_y_ready), .flt_y_data(flt_y_data),
        .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_data(dst_data),
        .in_count(in_count), .out_count(out_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_q [$];
    logic [W-1:0] fq [$];
    int done_cnt        = 0;
    int out_beats_frame = 0;
    int exp_outs        = 8;
    int fwd_cnt         = 0;
    int fwd_limit       = 1000000;
    int dst_mode        = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: scoreboard compare on each dst beat, frame_done framing checks.
    initial begin
        logic prev_fd;
        prev_fd = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                out_beats_frame = 0;
                prev_fd = 1'b0;
            end else begin
                if (dst_valid && dst_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("dst_unexpected_beat", 1, 0);
                    end else begin
                        chk("dst_data", int'(dst_data), int'(exp_q.pop_front()));
                    end
                    out_beats_frame++;
                end
                if (frame_done) begin
                    chk("frame_done_width", int'(prev_fd), 0);
                    chk("outputs_before_done", out_beats_frame, exp_outs);
                    done_cnt++;
                    out_beats_frame = 0;
                end
                prev_fd = frame_done;
            end
        end
    end

    // Echo filter model: each accepted x beat reappears on y; drops beyond fwd_limit.
    initial begin
        logic xb, yb;
        logic [W-1:0] xd;
        flt_y_valid = 1'b0;
        flt_y_data  = '0;
        flt_x_ready = 1'b1;
        forever begin
            @(negedge clk);
            xb = flt_x_valid && flt_x_ready;
            xd = flt_x_data;
            yb = flt_y_valid && flt_y_ready;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                fq.delete();
            end else begin
                if (yb && (fq.size() > 0)) void'(fq.pop_front());
                if (xb) begin
                    if (fwd_cnt < fwd_limit) fq.push_back(xd);
                    fwd_cnt++;
                end
            end
            flt_y_valid = (fq.size() > 0);
            flt_y_data  = (fq.size() > 0) ? fq[0] : 8'h00;
        end
    end

    // Sink ready: held high, or toggled randomly when dst_mode==1.
    initial begin
        dst_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            dst_ready = (dst_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int a, input int d);
        cfg_we   = 1'b1;
        cfg_addr = 4'(a);
        cfg_data = 8'(d);
        tick();
        cfg_we   = 1'b0;
    endtask

    // Start pulse; optionally writes a coefficient during the LOAD cycle. Returns in STREAM.
    task automatic pulse_start(input bit wr, input int a, input int d);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (wr) begin
            cfg_we   = 1'b1;
            cfg_addr = 4'(a);
            cfg_data = 8'(d);
        end
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic send_pixels(input int n, input int base, input bit gaps);
        for (int i = 0; i < n; i++) begin
            logic acc;
            logic [W-1:0] d;
            if (gaps) begin
                src_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            d = 8'(base + i * 7);
            src_valid = 1'b1;
            src_data  = d;
            exp_q.push_back(d);
            acc = 1'b0;
            for (int t = 0; t < 100 && !acc; t++) begin
                @(negedge clk);
                acc = src_ready;
                tick();
            end
            if (!acc) chk("src_accept_timeout", 0, 1);
        end
        src_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string nm);
        for (int t = 0; t < 400 && done_cnt == d0; t++) tick();
        repeat (2) tick();
        chk({nm, "_done_pulses"}, done_cnt - d0, 1);
        chk({nm, "_busy_after"}, int'(busy), 0);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_frame_done"}, int'(frame_done), 0);
        chk({nm, "_timeout"}, int'(timeout), 0);
        chk({nm, "_in_count"}, int'(in_count), 0);
        chk({nm, "_out_count"}, int'(out_count), 0);
        chk({nm, "_src_ready"}, int'(src_ready), 0);
        chk({nm, "_dst_valid"}, int'(dst_valid), 0);
        chk({nm, "_flt_x_valid"}, int'(flt_x_valid), 0);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                chk({nm, "_kernel"}, int'(kernel[r][c]), 0);
    endtask

    initial begin
        int d0;
        int cnt;
        int kexp [9];
        rst_n = 1'b0; start = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        src_valid = 1'b0; src_data = '0;
        repeat (3) tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();
        chk("idle_busy", int'(busy), 0);

        // Basic frame with coefficients 1..9
        for (int i = 0; i < 9; i++) cfg_write(i, i + 1);
        d0 = done_cnt; exp_outs = 8;
        pulse_start(1'b0, 0, 0);
        chk("t1_k11", int'(kernel[1][1]), 5);
        chk("t1_k00", int'(kernel[0][0]), 1);
        chk("t1_k22", int'(kernel[2][2]), 9);
        chk("t1_busy", int'(busy), 1);
        chk("t1_in_cleared", int'(in_count), 0);
        send_pixels(8, 8'h11, 1'b0);
        chk("t1_src_ready_after_last", int'(src_ready), 0);
        wait_done(d0, "t1");
        chk("t1_in_count", int'(in_count), 8);
        chk("t1_out_count", int'(out_count), 8);

        // Random backpressure and source gaps
        dst_mode = 1;
        d0 = done_cnt;
        pulse_start(1'b0, 0, 0);
        send_pixels(8, 8'hA0, 1'b1);
        chk("t2_src_ready_after_last", int'(src_ready), 0);
        wait_done(d0, "t2");
        dst_mode = 0;
        chk("t2_in_count", int'(in_count), 8);
        chk("t2_out_count", int'(out_count), 8);
        chk("t2_queue_empty", exp_q.size(), 0);

        // Shadow writes mid-frame and during LOAD are deferred; addr 12 ignored
        d0 = done_cnt;
        pulse_start(1'b1, 0, 11);
        chk("t3_k00_load_write_deferred", int'(kernel[0][0]), 1);
        send_pixels(3, 8'h40, 1'b0);
        cfg_write(4, -3);
        cfg_write(12, 7);
        chk("t3_k11_midframe", int'(kernel[1][1]), 5);
        send_pixels(5, 8'h60, 1'b0);
        wait_done(d0, "t3");
        chk("t3_k11_after_done", int'(kernel[1][1]), 5);
        kexp = '{11, 2, 3, 4, -3, 6, 7, 8, 9};
        d0 = done_cnt;
        pulse_start(1'b0, 0, 0);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                chk("t3_kernel_reload", int'(kernel[r][c]), kexp[r*3 + c]);
        send_pixels(8, 8'h80, 1'b0);
        wait_done(d0, "t3b");

        // Extra start mid-stream ignored; reset after 5 inputs abandons frame
        d0 = done_cnt;
        pulse_start(1'b0, 0, 0);
        send_pixels(2, 8'hC0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        send_pixels(3, 8'hD0, 1'b0);
        chk("t4_in_count_5", int'(in_count), 5);
        chk("t4_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_zero("t4_async_reset");
        repeat (2) tick();
        exp_q.delete();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("t4_idle_busy", int'(busy), 0);
        chk("t4_no_done", done_cnt - d0, 0);

        // Filter emits only 6 outputs
        fwd_limit = fwd_cnt + 6;
        exp_outs = 6;
        d0 = done_cnt;
        pulse_start(1'b0, 0, 0);
        send_pixels(8, 8'h21, 1'b0);
`ifdef CONV_SEQ_TIMEOUT_EN
        cnt = 0;
        for (int t = 0; t < 100 && !timeout; t++) begin
            tick();
            cnt++;
        end
        chk("t5_timeout_latency", cnt, 16);
        chk("t5_timeout", int'(timeout), 1);
        chk("t5_frame_done", int'(frame_done), 1);
        wait_done(d0, "t5");
        chk("t5_timeout_sticky", int'(timeout), 1);
        chk("t5_out_count", int'(out_count), 6);
        chk("t5_in_count", int'(in_count), 8);
        fwd_limit = 1000000;
        exp_outs = 8;
        pulse_start(1'b0, 0, 0);
        chk("t5_timeout_cleared_by_load", int'(timeout), 0);
`else
        cnt = 0;
        repeat (40) tick();
        chk("t5_busy_held", int'(busy), 1);
        chk("t5_timeout_zero", int'(timeout), 0);
        chk("t5_no_done", done_cnt - d0, 0);
        chk("t5_out_count", int'(out_count), 6);
`endif
        rst_n = 1'b0;
        repeat (2) tick();
        exp_q.delete();
        fwd_limit = 1000000;
        rst_n = 1'b1;
        repeat (2) tick();
        chk("end_idle_busy", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_frame_sequencer.md
CONV_FRAME_SEQUENCER -- requirements
Module: conv_frame_sequencer

Interface
REQ-001 SHALL have parameters: IMG_WIDTH, default 640, pixels per line; IMG_HEIGHT, default 480, lines per frame; W, default 8, pixel/coefficient width; TIMEOUT_CYCLES, default 4096, drain watchdog limit.
REQ-002 SHALL define N = IMG_WIDTH*IMG_HEIGHT and CW = $clog2(N+1).
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk  input  1  clock; rst_n  input  1  async active-low reset.
REQ-004 SHALL have control ports: start  input  1  frame start pulse; busy  output  1  frame in progress; frame_done  output  1  one-cycle end-of-frame pulse; timeout  output  1  sticky drain watchdog flag.
REQ-005 SHALL have config ports: cfg_we  input  1  coefficient write strobe; cfg_addr  input  4  coefficient index, row-major 0..8; cfg_data  input  W  signed coefficient; kernel  output  signed W [0:2][0:2]  active kernel to the filter.
REQ-006 SHALL have source ports: src_valid  input  1; src_ready  output  1; src_data  input  W.
REQ-007 SHALL have filter-input ports: flt_x_valid  output  1; flt_x_ready  input  1; flt_x_data  output  W.
REQ-008 SHALL have filter-output ports: flt_y_valid  input  1; flt_y_ready  output  1; flt_y_data  input  W.
REQ-009 SHALL have sink ports: dst_valid  output  1; dst_ready  input  1; dst_data  output  W; in_count  output  CW  accepted input beats; out_count  output  CW  delivered output beats.

Function
REQ-010 SHALL implement FSM states IDLE, LOAD, STREAM, DRAIN, DONE.
REQ-011 IDLE: start=1 -> LOAD; start in any other state SHALL be ignored.
REQ-012 LOAD: lasts exactly one cycle; copies all 9 shadow coefficients to kernel; clears in_count and out_count; -> STREAM.
REQ-013 STREAM: flt_x_valid=src_valid, src_ready=flt_x_ready, flt_x_data=src_data, all combinational; any other state forces flt_x_valid=0 and src_ready=0.
REQ-014 An input beat (flt_x_valid && flt_x_ready) SHALL increment in_count; the beat making in_count=N SHALL move STREAM -> DRAIN.
REQ-015 In STREAM and DRAIN: dst_valid=flt_y_valid, flt_y_ready=dst_ready, dst_data=flt_y_data, all combinational; in other states both valid and ready forced 0.
REQ-016 An output beat (dst_valid && dst_ready) SHALL increment out_count, saturating at N.
REQ-017 DRAIN -> DONE when out_count=N, including when out_count reaches N during STREAM before in_count does.
REQ-018 Input and output beats in the same cycle SHALL both be counted.
REQ-019 DONE: frame_done=1 for exactly one cycle; -> IDLE.
REQ-020 busy SHALL be 1 in LOAD, STREAM, DRAIN and DONE; 0 in IDLE.
REQ-021 cfg_we=1 with cfg_addr<=8 SHALL write cfg_data to shadow[cfg_addr] in any state; cfg_addr>=9 SHALL be ignored.
REQ-022 kernel SHALL change only in LOAD; a shadow write in the LOAD cycle SHALL be visible in shadow but not applied until the next LOAD.
REQ-023 Counters and kernel SHALL be registered outputs.

Reset
REQ-024 rst_n=0 SHALL asynchronously force: state IDLE, busy=0, frame_done=0, timeout=0, in_count=0, out_count=0, all shadow and kernel coefficients 0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame; after release the block waits in IDLE for start.

Configuration
REQ-026 Macro CONV_SEQ_TIMEOUT_EN SHALL compile in a drain watchdog: a counter clears on each output beat and on entry to DRAIN and increments every DRAIN cycle without an output beat.
REQ-027 With CONV_SEQ_TIMEOUT_EN, reaching TIMEOUT_CYCLES SHALL set timeout=1 (sticky until reset or the next LOAD) and move DRAIN -> DONE.
REQ-028 Without CONV_SEQ_TIMEOUT_EN, there SHALL be no watchdog logic, timeout SHALL be tied 0, and DRAIN SHALL wait indefinitely.

Verification (IMG_WIDTH=4, IMG_HEIGHT=2, N=8, TIMEOUT_CYCLES=16)
REQ-029 Write cfg 0..8 = 1..9, pulse start, stream 8 pixels with filter echoing data and dst_ready=1 -> kernel[1][1]=5 from LOAD, in_count=out_count=8, one frame_done pulse, busy returns to 0.
REQ-030 Toggle dst_ready and src_valid randomly -> no beat lost or duplicated, src_ready=0 after the 8th input, frame_done only after the 8th output.
REQ-031 Write cfg_addr 4 = -3 mid-frame, then cfg_addr 12 = 7 -> kernel[1][1] unchanged until the next start, then -3; the addr-12 write has no effect.
REQ-032 Pulse start during STREAM, and assert rst_n=0 after 5 inputs -> the extra start is ignored; after reset all outputs are 0 and the state is IDLE.
REQ-033 With CONV_SEQ_TIMEOUT_EN, filter emits only 6 outputs -> 16 DRAIN cycles later timeout=1 and frame_done pulses; without the macro, busy stays 1 and timeout stays 0.
